mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 64, byte-address width; NUM_TAGS, default 15, memory tags (tag 0 = none); DATA_W, default 64, bus data width; STARVE_LIMIT, default 8, consecutive port-1 denials before forced grant.
REQ-002 Derived: TAG_W = clog2(NUM_TAGS)+1; CNT_W = clog2(NUM_TAGS+1).
REQ-003 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 p0_addr  in  ADDR_W  port-0 (demand/L1/victim) address; p0_cmd  in  2  NONE=0, LOAD=1, STORE=2; p0_wdata  in  DATA_W  store data.
REQ-005 p0_response  out  TAG_W  accepted tag, 0 = not accepted; p0_tag  out  TAG_W  returning tag; p0_rdata  out  DATA_W  returning data.
REQ-006 p1_addr  in  ADDR_W; p1_cmd  in  2  (prefetcher, LOAD only); p1_response  out  TAG_W; p1_tag  out  TAG_W; p1_rdata  out  DATA_W.
REQ-007 mem_addr  out  ADDR_W; mem_cmd  out  2; mem_wdata  out  DATA_W; mem_response  in  TAG_W; mem_tag  in  TAG_W; mem_rdata  in  DATA_W.
REQ-008 p0_outstanding  out  CNT_W; p1_outstanding  out  CNT_W  loads issued, data not yet returned.

Function
REQ-009 Grant combinational each cycle: port 0 if p0_cmd!=NONE and not forced; else port 1 if p1_cmd!=NONE; else none.
REQ-010 Forced: starve_cnt == STARVE_LIMIT and p1_cmd!=NONE -> grant port 1 even if port 0 requests.
REQ-011 mem_addr/mem_cmd/mem_wdata = granted port's; no grant -> mem_cmd = NONE, addr/wdata = 0.
REQ-012 mem_response routed only to granted port's *_response; non-granted port sees 0 same cycle.
REQ-013 starve_cnt: +1 when p1_cmd!=NONE and port 1 not granted; cleared when port 1 granted and mem_response!=0, or p1_cmd==NONE; saturates at STARVE_LIMIT.
REQ-014 Forced grant persists until accepted (mem_response!=0); port 0 waits meanwhile.
REQ-015 Owner table: per tag 1..NUM_TAGS, valid bit + owner bit; on granted LOAD with mem_response=T!=0: valid[T]<=1, owner[T]<=port.
REQ-016 STORE acceptance forwards response to requester but does not touch owner table or counters.
REQ-017 Return: mem_tag=T!=0 with valid[T] -> owner gets *_tag=T, *_rdata=mem_rdata; other port tag 0; valid[T] cleared next edge.
REQ-018 mem_tag with valid[T]=0 (stale/store) -> dropped; both ports tag 0.
REQ-019 Same cycle completion of T and new issue of T: completion routed to old owner; table ends valid, new owner.
REQ-020 *_rdata = mem_rdata unconditionally; consumers qualify by *_tag!=0.
REQ-021 *_outstanding: +1 on own LOAD acceptance, -1 on own routed return; both same cycle -> unchanged; never wrap.
REQ-022 Only outputs 2-cycle-path-free: all outputs except counters combinational from inputs + table; no added latency.

Reset
REQ-023 reset: all valid bits 0, starve_cnt 0, both outstanding 0; in-flight returns after reset dropped per REQ-018.
REQ-024 Reset cycle: mem_cmd = NONE, both *_response and *_tag = 0 regardless of inputs.

Verification
REQ-025 p0 LOAD 0x100, p1 LOAD 0x200 same cycle, mem_response=3 -> mem_addr=0x100, p0_response=3, p1_response=0; later mem_tag=3 -> p0_tag=3, p1_tag=0, p0_outstanding 1->0.
REQ-026 p0 LOAD held 8 cycles, p1 LOAD held, mem_response=1 always -> cycle 9 mem_addr=p1_addr, p1_response=1, starve_cnt 0 next.
REQ-027 p1 LOAD accepted tag 5; cycle where mem_tag=5 and p0 LOAD accepted tag 5 -> p1_tag=5; next mem_tag=5 -> p0_tag=5.
REQ-028 p0 STORE accepted tag 2, then mem_tag=2 -> both tags 0, outstanding unchanged.
REQ-029 p1 accepted tags 1,2; reset; mem_tag=1 -> dropped, p1_outstanding 0.
REQ-030 Memory busy (mem_response=0) 4 cycles with p0 LOAD -> p0_response 0 throughout, table unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory request arbiter: port 0 has priority, and port 1 is force-granted after STARVE_LIMIT denials.
// Accepted load tags are recorded per port so that returning data goes back to the port that issued the load.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int NUM_TAGS     = 15,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 8,
    localparam int TAG_W       = $clog2(NUM_TAGS) + 1,
    localparam int CNT_W       = $clog2(NUM_TAGS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [1:0]        p0_cmd,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [TAG_W-1:0]  p0_response,
    output logic [TAG_W-1:0]  p0_tag,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [1:0]        p1_cmd,
    output logic [TAG_W-1:0]  p1_response,
    output logic [TAG_W-1:0]  p1_tag,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_cmd,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [TAG_W-1:0]  mem_response,
    input  logic [TAG_W-1:0]  mem_tag,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  p0_outstanding,
    output logic [CNT_W-1:0]  p1_outstanding
);

    localparam int SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam int TAG_NB = 2 ** TAG_W;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_STORE = 2'd2
    } cmd_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } grant_e;

    logic [TAG_NB-1:0] valid_q, valid_d;
    logic [TAG_NB-1:0] owner_q, owner_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [CNT_W-1:0]  p0_cnt_q, p0_cnt_d;
    logic [CNT_W-1:0]  p1_cnt_q, p1_cnt_d;

    grant_e grant;
    logic   forced;
    logic   issue_load;
    logic   ret_hit;
    logic   ret_owner;
    logic   inc0, inc1, dec0, dec1;

    always_comb begin
        grant       = GNT_NONE;
        forced      = (starve_q == SC_W'(STARVE_LIMIT)) && (p1_cmd != CMD_NONE);
        mem_addr    = '0;
        mem_cmd     = CMD_NONE;
        mem_wdata   = '0;
        p0_response = '0;
        p1_response = '0;
        p0_tag      = '0;
        p1_tag      = '0;
        p0_rdata    = mem_rdata;
        p1_rdata    = mem_rdata;
        issue_load  = 1'b0;
        ret_hit     = 1'b0;
        ret_owner   = 1'b0;
        valid_d     = valid_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        p0_cnt_d    = p0_cnt_q;
        p1_cnt_d    = p1_cnt_q;

        if (!reset) begin
            if (p0_cmd != CMD_NONE && !forced) grant = GNT_P0;
            else if (p1_cmd != CMD_NONE)       grant = GNT_P1;
        end

        if (grant == GNT_P0) begin
            mem_addr    = p0_addr;
            mem_cmd     = p0_cmd;
            mem_wdata   = p0_wdata;
            p0_response = mem_response;
            issue_load  = (p0_cmd == CMD_LOAD);
        end else if (grant == GNT_P1) begin
            mem_addr    = p1_addr;
            mem_cmd     = p1_cmd;
            p1_response = mem_response;
            issue_load  = (p1_cmd == CMD_LOAD);
        end
        // A zero or out-of-range tag means the load was not taken by memory.
        issue_load = issue_load && (mem_response != '0) && (mem_response <= TAG_W'(NUM_TAGS));

        if (!reset && mem_tag != '0 && valid_q[mem_tag]) begin
            ret_hit   = 1'b1;
            ret_owner = owner_q[mem_tag];
        end
        if (ret_hit && !ret_owner) p0_tag = mem_tag;
        if (ret_hit &&  ret_owner) p1_tag = mem_tag;

        // Clear before set so a same-cycle reissue of the returning tag keeps the entry live.
        if (ret_hit) valid_d[mem_tag] = 1'b0;
        if (issue_load) begin
            valid_d[mem_response] = 1'b1;
            owner_d[mem_response] = (grant == GNT_P1);
        end

        inc0 = issue_load && (grant == GNT_P0);
        inc1 = issue_load && (grant == GNT_P1);
        dec0 = ret_hit && !ret_owner;
        dec1 = ret_hit &&  ret_owner;
        if (inc0 && !dec0 && p0_cnt_q != '1) p0_cnt_d = p0_cnt_q + CNT_W'(1);
        if (dec0 && !inc0 && p0_cnt_q != '0) p0_cnt_d = p0_cnt_q - CNT_W'(1);
        if (inc1 && !dec1 && p1_cnt_q != '1) p1_cnt_d = p1_cnt_q + CNT_W'(1);
        if (dec1 && !inc1 && p1_cnt_q != '0) p1_cnt_d = p1_cnt_q - CNT_W'(1);

        // A forced grant that memory has not yet accepted keeps the count at the limit.
        if (p1_cmd == CMD_NONE)
            starve_d = '0;
        else if (grant == GNT_P1 && mem_response != '0)
            starve_d = '0;
        else if (grant != GNT_P1 && starve_q != SC_W'(STARVE_LIMIT))
            starve_d = starve_q + SC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            owner_q  <= '0;
            starve_q <= '0;
            p0_cnt_q <= '0;
            p1_cnt_q <= '0;
        end else begin
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            p0_cnt_q <= p0_cnt_d;
            p1_cnt_q <= p1_cnt_d;
        end
    end

    assign p0_outstanding = p0_cnt_q;
    assign p1_outstanding = p1_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// plus a per-cycle comparison against a tag-ownership model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int NUM_TAGS = 15;
    localparam int DATA_W = 64;
    localparam int LIMIT = 8;
    localparam int TAG_W = $clog2(NUM_TAGS) + 1;
    localparam int CNT_W = $clog2(NUM_TAGS + 1);

    logic clk = 1'b0;
    logic reset;
    logic [ADDR_W-1:0] p0_addr, p1_addr, mem_addr;
    logic [1:0] p0_cmd, p1_cmd, mem_cmd;
    logic [DATA_W-1:0] p0_wdata, mem_wdata, p0_rdata, p1_rdata, mem_rdata;
    logic [TAG_W-1:0] p0_response, p0_tag, p1_response, p1_tag, mem_response, mem_tag;
    logic [CNT_W-1:0] p0_outstanding, p1_outstanding;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .NUM_TAGS(NUM_TAGS), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .p0_addr(p0_addr), .p0_cmd(p0_cmd), .p0_wdata(p0_wdata),
        .p0_response(p0_response), .p0_tag(p0_tag), .p0_rdata(p0_rdata),
        .p1_addr(p1_addr), .p1_cmd(p1_cmd),
        .p1_response(p1_response), .p1_tag(p1_tag), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_wdata(mem_wdata),
        .mem_response(mem_response), .mem_tag(mem_tag), .mem_rdata(mem_rdata),
        .p0_outstanding(p0_outstanding), .p1_outstanding(p1_outstanding)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner of each live tag (-1 = none), per-port load counts, denial streak.
    int own [32];
    int cnt [2];
    int starve;

    initial begin
        for (int i = 0; i < 32; i++) own[i] = -1;
        cnt[0] = 0;
        cnt[1] = 0;
        starve = 0;
    end

    always @(negedge clk) begin
        int g;
        int ret;
        logic [63:0] ea, ew;
        logic [1:0] ec;
        if (reset) g = -1;
        else if (p0_cmd != 0 && !(starve == LIMIT && p1_cmd != 0)) g = 0;
        else if (p1_cmd != 0) g = 1;
        else g = -1;
        ea = (g == 0) ? p0_addr : (g == 1) ? p1_addr : 64'd0;
        ec = (g == 0) ? p0_cmd : (g == 1) ? p1_cmd : 2'd0;
        ew = (g == 0) ? p0_wdata : 64'd0;
        ret = (!reset && mem_tag != 0) ? own[mem_tag] : -1;

        chk("m_mem_addr", mem_addr, ea);
        chk("m_mem_cmd", 64'(mem_cmd), 64'(ec));
        chk("m_mem_wdata", mem_wdata, ew);
        chk("m_p0_response", 64'(p0_response), (g == 0) ? 64'(mem_response) : 64'd0);
        chk("m_p1_response", 64'(p1_response), (g == 1) ? 64'(mem_response) : 64'd0);
        chk("m_p0_tag", 64'(p0_tag), (ret == 0) ? 64'(mem_tag) : 64'd0);
        chk("m_p1_tag", 64'(p1_tag), (ret == 1) ? 64'(mem_tag) : 64'd0);
        chk("m_p0_rdata", p0_rdata, mem_rdata);
        chk("m_p1_rdata", p1_rdata, mem_rdata);
        chk("m_p0_outstanding", 64'(p0_outstanding), 64'(cnt[0]));
        chk("m_p1_outstanding", 64'(p1_outstanding), 64'(cnt[1]));

        if (reset) begin
            for (int i = 0; i < 32; i++) own[i] = -1;
            cnt[0] = 0;
            cnt[1] = 0;
            starve = 0;
        end else begin
            if (ret >= 0) begin
                own[mem_tag] = -1;
                if (cnt[ret] > 0) cnt[ret]--;
            end
            if (g >= 0 && ec == 2'd1 && mem_response != 0) begin
                own[mem_response] = g;
                if (cnt[g] < NUM_TAGS) cnt[g]++;
            end
            if (p1_cmd == 0) starve = 0;
            else if (g == 1 && mem_response != 0) starve = 0;
            else if (g != 1 && starve < LIMIT) starve++;
        end
    end

    task automatic drive(input logic [1:0] c0, input logic [63:0] a0, input logic [63:0] w0,
                         input logic [1:0] c1, input logic [63:0] a1,
                         input logic [TAG_W-1:0] rsp, input logic [TAG_W-1:0] tg,
                         input logic [63:0] rd);
        p0_cmd = c0; p0_addr = a0; p0_wdata = w0;
        p1_cmd = c1; p1_addr = a1;
        mem_response = rsp; mem_tag = tg; mem_rdata = rd;
    endtask

    task automatic idle();
        drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, '0, '0, 64'd0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        next();
        next();
        reset = 1'b0;
    endtask

    initial begin
        // Reset with live-looking inputs: nothing may be granted or routed.
        reset = 1'b1;
        drive(2'd1, 64'h40, 64'd0, 2'd1, 64'h80, 5'd3, 5'd2, 64'h55);
        next();
        #1;
        chk("rst_mem_cmd", 64'(mem_cmd), 64'd0);
        chk("rst_p0_response", 64'(p0_response), 64'd0);
        chk("rst_p1_response", 64'(p1_response), 64'd0);
        chk("rst_p0_tag", 64'(p0_tag), 64'd0);
        next();
        chk("rst_p0_outstanding", 64'(p0_outstanding), 64'd0);
        reset = 1'b0;

        // Both ports load; port 0 wins, then its data returns.
        drive(2'd1, 64'h100, 64'd0, 2'd1, 64'h200, 5'd3, 5'd0, 64'd0);
        #1;
        chk("s25_mem_addr", mem_addr, 64'h100);
        chk("s25_p0_response", 64'(p0_response), 64'd3);
        chk("s25_p1_response", 64'(p1_response), 64'd0);
        next();
        idle();
        #1 chk("s25_p0_out_1", 64'(p0_outstanding), 64'd1);
        next();
        drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 5'd0, 5'd3, 64'hDEAD);
        #1;
        chk("s25_p0_tag", 64'(p0_tag), 64'd3);
        chk("s25_p1_tag", 64'(p1_tag), 64'd0);
        chk("s25_p0_rdata", p0_rdata, 64'hDEAD);
        next();
        idle();
        #1 chk("s25_p0_out_0", 64'(p0_outstanding), 64'd0);
        next();

        // Starvation: eight denials, then port 1 is forced through.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(2'd1, 64'h10, 64'd0, 2'd1, 64'h20, 5'd1, 5'd0, 64'd0);
            #1 chk("s26_p0_wins", mem_addr, 64'h10);
            next();
        end
        #1;
        chk("s26_forced_addr", mem_addr, 64'h20);
        chk("s26_p1_response", 64'(p1_response), 64'd1);
        chk("s26_p0_response", 64'(p0_response), 64'd0);
        next();
        chk("s26_after_force", mem_addr, 64'h10);
        next();

        // Tag 5 returns to port 1 while port 0 reissues tag 5.
        do_reset();
        drive(2'd0, 64'd0, 64'd0, 2'd1, 64'h500, 5'd5, 5'd0, 64'd0);
        #1 chk("s27_p1_response", 64'(p1_response), 64'd5);
        next();
        idle();
        next();
        drive(2'd1, 64'h600, 64'd0, 2'd0, 64'd0, 5'd5, 5'd5, 64'h77);
        #1;
        chk("s27_p1_tag", 64'(p1_tag), 64'd5);
        chk("s27_p0_tag_0", 64'(p0_tag), 64'd0);
        chk("s27_p0_response", 64'(p0_response), 64'd5);
        next();
        drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 5'd0, 5'd5, 64'h88);
        #1;
        chk("s27_p0_tag", 64'(p0_tag), 64'd5);
        chk("s27_p1_tag_0", 64'(p1_tag), 64'd0);
        next();
        idle();
        #1;
        chk("s27_p0_out", 64'(p0_outstanding), 64'd0);
        chk("s27_p1_out", 64'(p1_outstanding), 64'd0);
        next();

        // Store acceptance does not create an owner entry.
        drive(2'd2, 64'h300, 64'hAB, 2'd0, 64'd0, 5'd2, 5'd0, 64'd0);
        #1;
        chk("s28_mem_cmd", 64'(mem_cmd), 64'd2);
        chk("s28_mem_wdata", mem_wdata, 64'hAB);
        chk("s28_p0_response", 64'(p0_response), 64'd2);
        next();
        drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 5'd0, 5'd2, 64'h99);
        #1;
        chk("s28_p0_tag", 64'(p0_tag), 64'd0);
        chk("s28_p1_tag", 64'(p1_tag), 64'd0);
        chk("s28_p0_out", 64'(p0_outstanding), 64'd0);
        next();

        // In-flight port-1 loads are forgotten across reset.
        drive(2'd0, 64'd0, 64'd0, 2'd1, 64'h700, 5'd1, 5'd0, 64'd0);
        next();
        drive(2'd0, 64'd0, 64'd0, 2'd1, 64'h708, 5'd2, 5'd0, 64'd0);
        next();
        idle();
        #1 chk("s29_p1_out_2", 64'(p1_outstanding), 64'd2);
        next();
        do_reset();
        drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 5'd0, 5'd1, 64'h11);
        #1;
        chk("s29_p1_tag", 64'(p1_tag), 64'd0);
        chk("s29_p1_out_0", 64'(p1_outstanding), 64'd0);
        next();

        // Memory busy: no acceptance, no table change.
        for (int i = 0; i < 4; i++) begin
            drive(2'd1, 64'h900, 64'd0, 2'd0, 64'd0, 5'd0, 5'd0, 64'd0);
            #1 chk("s30_p0_response", 64'(p0_response), 64'd0);
            next();
        end
        drive(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 5'd0, 5'd4, 64'h22);
        #1;
        chk("s30_no_entry", 64'(p0_tag), 64'd0);
        chk("s30_p0_out", 64'(p0_outstanding), 64'd0);
        next();
        idle();
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
